// File: rtl/cpe_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpe_lsu: CPU load/store unit to word-aligned, byte-enabled req/ack bus.   |
// | Optional define CPE_LSU_MISALIGN_EN rejects misaligned half/word access.  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module cpe_lsu #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic        clk_w_i,
   input  logic        res_w_i_l,
   input  logic        mem_rd_w_i_h,
   input  logic        mem_wr_w_i_h,
   input  logic [31:0] mem_addr_w_i,
   input  logic [31:0] mem_data_w_i,
   input  logic [2:0]  funct_3_w_i,
   output logic        stall_w_o_h,
   output logic        done_w_o_h,
   output logic        err_w_o_h,
   output logic [31:0] load_data_w_o,
   output logic        bus_req_w_o_h,
   output logic        bus_we_w_o_h,
   output logic [31:0] bus_addr_w_o,
   output logic [3:0]  bus_be_w_o,
   output logic [31:0] bus_wdata_w_o,
   input  logic        bus_ack_w_i_h,
   input  logic [31:0] bus_rdata_w_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
   localparam bit               c_timeout_en = (TIMEOUT_CYCLES != 0);

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              r_err;
   logic              r_bus_req, r_bus_we;
   logic [31:0]       r_bus_addr, r_bus_wdata, r_load_data;
   logic [3:0]        r_bus_be;
   logic [2:0]        r_f3;
   logic [1:0]        r_lane;

   logic              w_f3_ok, w_misalign, w_legal;
   logic              w_issue, w_reject, w_ack_done, w_timeout, w_stall;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [1:0]        w_rsel;
   logic [31:0]       w_shifted, w_load_ext;

   always_comb begin
      case (funct_3_w_i)
         3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
         3'b100, 3'b101:         w_f3_ok = mem_rd_w_i_h;
         default:                w_f3_ok = 1'b0;
      endcase
   end

`ifdef CPE_LSU_MISALIGN_EN
   assign w_misalign = ((funct_3_w_i[1:0] == 2'b01) && mem_addr_w_i[0]) ||
                       ((funct_3_w_i[1:0] == 2'b10) && (mem_addr_w_i[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_legal   = (mem_rd_w_i_h ^ mem_wr_w_i_h) && w_f3_ok && !w_misalign;
   assign w_cnt_inc = r_cnt + c_cnt_one;

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_reject    = 1'b0;
      w_ack_done  = 1'b0;
      w_timeout   = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_stall = mem_rd_w_i_h | mem_wr_w_i_h;
            if (w_legal) begin
               w_issue     = 1'b1;
               w_state_nxt = ST_REQ;
            end else if (mem_rd_w_i_h | mem_wr_w_i_h) begin
               w_reject    = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_REQ: begin
            w_stall = 1'b1;
            if (bus_ack_w_i_h) begin
               w_ack_done  = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (c_timeout_en && (w_cnt_inc == c_timeout)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Byte/half stores replicate data across lanes so the bus can pick any lane.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = mem_data_w_i;
      case (funct_3_w_i[1:0])
         2'b00: begin
            w_be    = 4'b0001 << mem_addr_w_i[1:0];
            w_wdata = {4{mem_data_w_i[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << {mem_addr_w_i[1], 1'b0};
            w_wdata = {2{mem_data_w_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (r_f3[1:0])
         2'b00:   w_rsel = r_lane;
         2'b01:   w_rsel = {r_lane[1], 1'b0};
         default: w_rsel = 2'b00;
      endcase
      w_shifted = bus_rdata_w_i >> {w_rsel, 3'b000};
      case (r_f3)
         3'b000:  w_load_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
         3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
         3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
         default: w_load_ext = w_shifted;
      endcase
   end

   always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
      if (!res_w_i_l) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
      if (!res_w_i_l) begin
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 32'd0;
         r_bus_be    <= 4'd0;
         r_bus_wdata <= 32'd0;
         r_load_data <= 32'd0;
         r_f3        <= 3'd0;
         r_lane      <= 2'd0;
      end else begin
         r_err <= w_reject | w_timeout;
         if (r_state == ST_REQ) begin
            r_cnt <= w_cnt_inc;
         end else begin
            r_cnt <= '0;
         end
         if (w_issue) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_wr_w_i_h;
            r_bus_addr  <= {mem_addr_w_i[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_f3        <= funct_3_w_i;
            r_lane      <= mem_addr_w_i[1:0];
         end
         if (w_ack_done || w_timeout) begin
            r_bus_req <= 1'b0;
         end
         if (w_ack_done && !r_bus_we) begin
            r_load_data <= w_load_ext;
         end else if (w_timeout) begin
            r_load_data <= 32'd0;
         end
      end
   end

   // Stall is forced low while reset is held, even if the CPU is requesting.
   assign stall_w_o_h   = res_w_i_l & w_stall;
   assign done_w_o_h    = (r_state == ST_DONE);
   assign err_w_o_h     = r_err;
   assign load_data_w_o = r_load_data;
   assign bus_req_w_o_h = r_bus_req;
   assign bus_we_w_o_h  = r_bus_we;
   assign bus_addr_w_o  = r_bus_addr;
   assign bus_be_w_o    = r_bus_be;
   assign bus_wdata_w_o = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cpe_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpe_lsu: directed scoreboard bench for cpe_lsu.                        |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cpe_lsu;

   logic        clk_w_i = 1'b0;
   logic        res_w_i_l;
   logic        mem_rd_w_i_h, mem_wr_w_i_h;
   logic [31:0] mem_addr_w_i, mem_data_w_i;
   logic [2:0]  funct_3_w_i;
   logic        stall_w_o_h, done_w_o_h, err_w_o_h;
   logic [31:0] load_data_w_o;
   logic        bus_req_w_o_h, bus_we_w_o_h;
   logic [31:0] bus_addr_w_o, bus_wdata_w_o;
   logic [3:0]  bus_be_w_o;
   logic        bus_ack_w_i_h;
   logic [31:0] bus_rdata_w_i;

   int tests = 0;
   int fails = 0;
   logic [31:0] last_ld = 32'd0;

   typedef struct {
      string       tag;
      logic        err;
      logic        bus;
      logic        we;
      logic [31:0] baddr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] ld;
      int          reqs;
      int          stalls;
   } exp_t;
   exp_t sb[$];

   always #5 clk_w_i = ~clk_w_i;

   cpe_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk_w_i       (clk_w_i),
      .res_w_i_l     (res_w_i_l),
      .mem_rd_w_i_h  (mem_rd_w_i_h),
      .mem_wr_w_i_h  (mem_wr_w_i_h),
      .mem_addr_w_i  (mem_addr_w_i),
      .mem_data_w_i  (mem_data_w_i),
      .funct_3_w_i   (funct_3_w_i),
      .stall_w_o_h   (stall_w_o_h),
      .done_w_o_h    (done_w_o_h),
      .err_w_o_h     (err_w_o_h),
      .load_data_w_o (load_data_w_o),
      .bus_req_w_o_h (bus_req_w_o_h),
      .bus_we_w_o_h  (bus_we_w_o_h),
      .bus_addr_w_o  (bus_addr_w_o),
      .bus_be_w_o    (bus_be_w_o),
      .bus_wdata_w_o (bus_wdata_w_o),
      .bus_ack_w_i_h (bus_ack_w_i_h),
      .bus_rdata_w_i (bus_rdata_w_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one CPU request; ack_cyc is the REQ cycle (1-based) in which ack rises, 0 = never.
   task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                         input int ack_cyc, input logic e_err, input logic e_bus,
                         input logic [31:0] e_baddr, input logic [3:0] e_be, input logic [31:0] e_wd,
                         input logic e_ld_upd, input logic [31:0] e_ld, input int e_reqs);
      exp_t e, got;
      int stalls = 0;
      int reqs = 0;
      bit seen = 0;
      bit stable = 1;
      e.tag = tag; e.err = e_err; e.bus = e_bus; e.we = wr; e.baddr = e_baddr;
      e.be = e_be; e.wd = e_wd; e.ld = e_ld_upd ? e_ld : last_ld;
      e.reqs = e_reqs; e.stalls = e_reqs + 1;
      sb.push_back(e);
      mem_rd_w_i_h = rd; mem_wr_w_i_h = wr; funct_3_w_i = f3;
      mem_addr_w_i = addr; mem_data_w_i = data; bus_rdata_w_i = rdata;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (stall_w_o_h) stalls++;
         if (done_w_o_h) begin
            seen = 1;
            break;
         end
         chk({tag, " err_quiet"}, {31'd0, err_w_o_h}, 32'd0);
         if (bus_req_w_o_h) begin
            reqs++;
            if (reqs == 1) begin
               got.we = bus_we_w_o_h; got.baddr = bus_addr_w_o;
               got.be = bus_be_w_o;   got.wd = bus_wdata_w_o;
            end else if (got.we !== bus_we_w_o_h || got.baddr !== bus_addr_w_o ||
                         got.be !== bus_be_w_o || got.wd !== bus_wdata_w_o) begin
               stable = 0;
            end
            bus_ack_w_i_h = (ack_cyc != 0) && (reqs >= ack_cyc);
         end else begin
            bus_ack_w_i_h = 1'b0;
         end
         @(posedge clk_w_i);
      end
      bus_ack_w_i_h = 1'b0;
      e = sb.pop_front();
      chk({e.tag, " done_seen"}, {31'd0, seen}, 32'd1);
      chk({e.tag, " err"}, {31'd0, err_w_o_h}, {31'd0, e.err});
      chk({e.tag, " load_data"}, load_data_w_o, e.ld);
      chk({e.tag, " req_cycles"}, reqs, e.reqs);
      chk({e.tag, " stall_cycles"}, stalls, e.stalls);
      if (e.bus) begin
         chk({e.tag, " bus_we"}, {31'd0, got.we}, {31'd0, e.we});
         chk({e.tag, " bus_addr"}, got.baddr, e.baddr);
         chk({e.tag, " bus_be"}, {28'd0, got.be}, {28'd0, e.be});
         if (e.we) chk({e.tag, " bus_wdata"}, got.wd, e.wd);
         chk({e.tag, " bus_stable"}, {31'd0, stable}, 32'd1);
      end
      last_ld = e.ld;
      mem_rd_w_i_h = 1'b0; mem_wr_w_i_h = 1'b0;
      @(posedge clk_w_i); #1;
      chk({e.tag, " done_pulse_end"}, {31'd0, done_w_o_h}, 32'd0);
      chk({e.tag, " err_pulse_end"}, {31'd0, err_w_o_h}, 32'd0);
   endtask

   initial begin
      res_w_i_l = 1'b0;
      mem_rd_w_i_h = 1'b1; mem_wr_w_i_h = 1'b0; funct_3_w_i = 3'b010;
      mem_addr_w_i = 32'h100; mem_data_w_i = 32'd0;
      bus_ack_w_i_h = 1'b0; bus_rdata_w_i = 32'd0;
      #12;
      chk("rst stall", {31'd0, stall_w_o_h}, 32'd0);
      chk("rst bus_req", {31'd0, bus_req_w_o_h}, 32'd0);
      chk("rst done", {31'd0, done_w_o_h}, 32'd0);
      chk("rst load_data", load_data_w_o, 32'd0);
      chk("rst bus_be", {28'd0, bus_be_w_o}, 32'd0);
      mem_rd_w_i_h = 1'b0;
      #10 res_w_i_l = 1'b1;
      @(posedge clk_w_i); #1;

      //      tag         rd   wr   f3      addr          data          rdata         ack err bus baddr         be       wdata         upd ld            reqs
      access("lb_103",   1,   0,   3'b000, 32'h103,      32'h0,        32'h80FF_1234, 1, 0, 1, 32'h100,      4'b1000, 32'h0,        1, 32'hFFFF_FF80, 1);
      access("lhu_2002", 1,   0,   3'b101, 32'h2002,     32'h0,        32'h9ABC_1234, 1, 0, 1, 32'h2000,     4'b1100, 32'h0,        1, 32'h0000_9ABC, 1);
      access("lh_2002",  1,   0,   3'b001, 32'h2002,     32'h0,        32'h9ABC_1234, 1, 0, 1, 32'h2000,     4'b1100, 32'h0,        1, 32'hFFFF_9ABC, 1);
      access("lbu_102",  1,   0,   3'b100, 32'h102,      32'h0,        32'h80FF_1234, 2, 0, 1, 32'h100,      4'b0100, 32'h0,        1, 32'h0000_00FF, 2);
      access("lw_200",   1,   0,   3'b010, 32'h200,      32'h0,        32'hDEAD_BEEF, 1, 0, 1, 32'h200,      4'b1111, 32'h0,        1, 32'hDEAD_BEEF, 1);
      access("sb_41",    0,   1,   3'b000, 32'h41,       32'h0000_00A5, 32'h0,        5, 0, 1, 32'h40,       4'b0010, 32'hA5A5_A5A5, 0, 32'h0,         5);
      access("sh_82",    0,   1,   3'b001, 32'h82,       32'h1234_5678, 32'h0,        1, 0, 1, 32'h80,       4'b1100, 32'h5678_5678, 0, 32'h0,         1);
      access("sw_10",    0,   1,   3'b010, 32'h10,       32'hCAFE_F00D, 32'h0,        3, 0, 1, 32'h10,       4'b1111, 32'hCAFE_F00D, 0, 32'h0,         3);
      access("rd_and_wr",1,   1,   3'b010, 32'h20,       32'h0,        32'h0,         1, 1, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,         0);
      access("f3_011",   1,   0,   3'b011, 32'h20,       32'h0,        32'h0,         1, 1, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,         0);
      access("st_f3_100",0,   1,   3'b100, 32'h20,       32'h0,        32'h0,         1, 1, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,         0);
`ifdef CPE_LSU_MISALIGN_EN
      access("lw_6_mis", 1,   0,   3'b010, 32'h6,        32'h0,        32'h1357_9BDF, 1, 1, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,         0);
      access("lh_3_mis", 1,   0,   3'b001, 32'h3,        32'h0,        32'h8001_7FFF, 1, 1, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,         0);
`else
      access("lw_6",     1,   0,   3'b010, 32'h6,        32'h0,        32'h1357_9BDF, 1, 0, 1, 32'h4,        4'b1111, 32'h0,        1, 32'h1357_9BDF, 1);
      access("lh_3",     1,   0,   3'b001, 32'h3,        32'h0,        32'h8001_7FFF, 1, 0, 1, 32'h0,        4'b1100, 32'h0,        1, 32'hFFFF_8001, 1);
`endif
      access("timeout",  1,   0,   3'b010, 32'h300,      32'h0,        32'h1111_1111, 0, 1, 1, 32'h300,      4'b1111, 32'h0,        1, 32'h0,         16);
      access("lb_5_pre", 1,   0,   3'b000, 32'h5,        32'h0,        32'h0000_7F00, 1, 0, 1, 32'h4,        4'b0010, 32'h0,        1, 32'h0000_007F, 1);

      // Asynchronous reset in the middle of an outstanding transaction.
      mem_rd_w_i_h = 1'b1; funct_3_w_i = 3'b010; mem_addr_w_i = 32'h404;
      @(posedge clk_w_i); #1;
      chk("mid_rst req_before", {31'd0, bus_req_w_o_h}, 32'd1);
      #2 res_w_i_l = 1'b0;
      #1;
      chk("mid_rst bus_req", {31'd0, bus_req_w_o_h}, 32'd0);
      chk("mid_rst stall", {31'd0, stall_w_o_h}, 32'd0);
      chk("mid_rst load_data", load_data_w_o, 32'd0);
      chk("mid_rst bus_addr", bus_addr_w_o, 32'd0);
      chk("mid_rst bus_be", {28'd0, bus_be_w_o}, 32'd0);
      mem_rd_w_i_h = 1'b0;
      #2 res_w_i_l = 1'b1;
      bus_ack_w_i_h = 1'b1; bus_rdata_w_i = 32'hFFFF_FFFF;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk_w_i); #1;
         chk("late_ack done", {31'd0, done_w_o_h}, 32'd0);
         chk("late_ack bus_req", {31'd0, bus_req_w_o_h}, 32'd0);
         chk("late_ack load_data", load_data_w_o, 32'd0);
      end
      bus_ack_w_i_h = 1'b0;
      last_ld = 32'd0;
      access("lw_after",  1,  0,   3'b010, 32'h500,      32'h0,        32'h2468_ACE0, 1, 0, 1, 32'h500,      4'b1111, 32'h0,        1, 32'h2468_ACE0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
